// File: rtl/pc_sequencer_pkg.sv
// Shared FSM state encoding and default address constants for the PC sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0180;
  localparam int unsigned INC_DEF          = 4;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select for the RUN state: priority resolution of
// trap, return, jump, branch, stall and fetch handshake.
module pc_next_mux #(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  EXC_VECTOR = '0,
  parameter int unsigned       INC        = 4
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_epc,
  input  logic             i_stall,
  input  logic             i_branch,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic             i_exception,
  input  logic             i_eret,
  input  logic             i_fetch_valid,
  input  logic             i_fetch_ready,
  output logic [WIDTH-1:0] o_pc_nxt,
  output logic [WIDTH-1:0] o_epc_nxt,
  output logic             o_trap,
  output logic             o_misaligned
);

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;

  always_comb begin
    o_pc_nxt     = i_pc;
    o_epc_nxt    = i_epc;
    o_trap       = 1'b0;
    o_misaligned = 1'b0;
    w_redirect   = 1'b0;
    w_target     = i_pc;

    if (i_exception) begin
      o_trap    = 1'b1;
      o_epc_nxt = i_pc;
      o_pc_nxt  = EXC_VECTOR;
    end else begin
      // Eret bypasses Stall; Jump/Branch are dropped while stalled.
      if (i_eret) begin
        w_redirect = 1'b1;
        w_target   = i_epc;
      end else if (!i_stall && i_jump) begin
        w_redirect = 1'b1;
        w_target   = i_jump_target;
      end else if (!i_stall && i_branch) begin
        w_redirect = 1'b1;
        w_target   = i_branch_target;
      end

      if (w_redirect) begin
        if (w_target[1:0] != 2'b00) begin
          o_trap       = 1'b1;
          o_misaligned = 1'b1;
          o_epc_nxt    = w_target;
          o_pc_nxt     = EXC_VECTOR;
        end else begin
          o_pc_nxt = w_target;
        end
      end else if (!i_stall && i_fetch_valid && i_fetch_ready) begin
        o_pc_nxt = i_pc + WIDTH'(INC);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/TRAP FSM with registered PC, EPC and status;
// every redirect or trap takes effect on the next rising edge.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
  parameter int unsigned      INC          = INC_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Exception,
  input  logic             Eret,
  input  logic             FetchReady,
  output logic [WIDTH-1:0] PCResult,
  output logic             FetchValid,
  output logic [WIDTH-1:0] EPC,
  output logic             Misaligned
);

  pc_state_t        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, r_epc;
  logic             r_fetch_valid, r_misaligned;

  logic [WIDTH-1:0] w_pc_nxt, w_epc_nxt;
  logic             w_mis_nxt;
  logic [WIDTH-1:0] w_mux_pc, w_mux_epc;
  logic             w_mux_trap, w_mux_mis;

  pc_next_mux #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR),
    .INC        (INC)
  ) u_next_mux (
    .i_pc            (r_pc),
    .i_epc           (r_epc),
    .i_stall         (Stall),
    .i_branch        (BranchTaken),
    .i_branch_target (BranchTarget),
    .i_jump          (Jump),
    .i_jump_target   (JumpTarget),
    .i_exception     (Exception),
    .i_eret          (Eret),
    .i_fetch_valid   (r_fetch_valid),
    .i_fetch_ready   (FetchReady),
    .o_pc_nxt        (w_mux_pc),
    .o_epc_nxt       (w_mux_epc),
    .o_trap          (w_mux_trap),
    .o_misaligned    (w_mux_mis)
  );

  // Control inputs only matter in RUN; BOOT and TRAP hold PC/EPC for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_mis_nxt   = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_pc_nxt  = w_mux_pc;
        w_epc_nxt = w_mux_epc;
        w_mis_nxt = w_mux_mis;
        if (w_mux_trap) w_state_nxt = ST_TRAP;
      end
      ST_TRAP: w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_VECTOR;
      r_epc         <= '0;
      r_fetch_valid <= 1'b0;
      r_misaligned  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_epc         <= w_epc_nxt;
      r_fetch_valid <= (w_state_nxt == ST_RUN);
      r_misaligned  <= w_mis_nxt;
    end
  end

  assign PCResult   = r_pc;
  assign FetchValid = r_fetch_valid;
  assign EPC        = r_epc;
  assign Misaligned = r_misaligned;

endmodule
